// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e   : arbiter FSM state encoding (IDLE / BURST)
//   burst_cnt_w() : width of the per-burst word counter, clog2(max_burst+1)
//   idx_w()       : width of a requester index (at least 1 bit)
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // The counter must be able to hold max_burst itself.
   function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i      : request vector
//   last_ptr_i : index of the most recent owner; search starts one above it
//   onehot_o   : one-hot winner (zero when no request)
//   idx_o      : winner index
//   valid_o    : any request present
module rr_priority_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [IW-1:0] cand;

   // Walk N candidates starting at last_ptr+1 with wrap; the first hit wins.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IW'((32'(last_ptr_i) + i) % N);
         if (!valid_o && req_i[cand]) begin
            valid_o        = 1'b1;
            idx_o          = cand;
            onehot_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one downstream FIFO write port.
//   clk_i, rst_i (async, active low), clk_en_i (low freezes everything)
//   req_i / last_i / data_i : per-requester request, end-of-burst, packed data
//   ack_o         : one-hot word-accepted strobe
//   grant_o       : registered one-hot owner, zero in IDLE
//   fifo_w_en_o / fifo_w_data_o / fifo_full_i : downstream FIFO write side
//   busy_o        : high while a burst is owned
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned data_word_size_g = 8,
   parameter int unsigned num_req_g        = 4,
   parameter int unsigned max_burst_g      = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  clk_en_i,
   input  logic [num_req_g-1:0]                  req_i,
   input  logic [num_req_g-1:0]                  last_i,
   input  logic [num_req_g*data_word_size_g-1:0] data_i,
   output logic [num_req_g-1:0]                  ack_o,
   output logic [num_req_g-1:0]                  grant_o,
   output logic                                  fifo_w_en_o,
   output logic [data_word_size_g-1:0]           fifo_w_data_o,
   input  logic                                  fifo_full_i,
   output logic                                  busy_o
);

   localparam int unsigned IW = idx_w(num_req_g);
   localparam int unsigned CW = burst_cnt_w(max_burst_g);
   localparam logic [CW-1:0] MAX_CNT = CW'(max_burst_g);

   arb_state_e            state_q;
   logic [num_req_g-1:0]  grant_q;
   logic [IW-1:0]         gidx_q, last_ptr_q;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [num_req_g-1:0]  pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_vld;

   logic                  req_g, last_g, xfer, burst_done;
   logic [data_word_size_g-1:0] data_g;

   rr_priority_pick #(.N(num_req_g), .IW(IW)) u_pick (
      .req_i      (req_i),
      .last_ptr_i (last_ptr_q),
      .onehot_o   (pick_oh),
      .idx_o      (pick_idx),
      .valid_o    (pick_vld)
   );

   // Select the owner's request, marker and data word.
   always_comb begin
      req_g  = req_i[gidx_q];
      last_g = last_i[gidx_q];
      data_g = '0;
      for (int unsigned k = 0; k < num_req_g; k++)
         if (gidx_q == IW'(k)) data_g = data_i[k*data_word_size_g +: data_word_size_g];
   end

   // A word moves only in BURST with the owner requesting and FIFO space.
   // Reset clears state_q asynchronously, so this is also zero during reset.
   assign xfer  = clk_en_i && (state_q == ST_BURST) && req_g && !fifo_full_i;
   assign cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;

   // Release on marked last word, on hitting the burst cap, or when the owner
   // drops its request (an enabled cycle with req low).
   assign burst_done = (xfer && (last_g || cnt_d == MAX_CNT)) || (clk_en_i && !req_g);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         cnt_q      <= '0;
         last_ptr_q <= IW'(num_req_g - 1);
      end else if (clk_en_i) begin
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  state_q <= ST_BURST;
                  grant_q <= pick_oh;
                  gidx_q  <= pick_idx;
                  cnt_q   <= '0;
               end
            end
            ST_BURST: begin
               cnt_q <= cnt_d;
               if (burst_done) begin
                  state_q    <= ST_IDLE;
                  grant_q    <= '0;
                  last_ptr_q <= gidx_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack_o         = xfer ? grant_q : '0;
   assign fifo_w_en_o   = xfer;
   assign fifo_w_data_o = data_g;
   assign grant_o       = grant_q;
   assign busy_o        = (state_q == ST_BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter data_word_size_g, 8, width of one data word.
REQ-002 SHALL have parameter num_req_g, 4, number of requesters (2..16).
REQ-003 SHALL have parameter max_burst_g, 8, maximum words per grant (1..255).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clk_en_i  input  1  clock enable; low freezes all state.
REQ-007 SHALL have port req_i  input  num_req_g  per-requester write request, level.
REQ-008 SHALL have port last_i  input  num_req_g  per-requester end-of-burst marker, qualified by the accepted word.
REQ-009 SHALL have port data_i  input  num_req_g*data_word_size_g  packed write data, requester k at bits [k*W +: W].
REQ-010 SHALL have port ack_o  output  num_req_g  one-hot; word of requester k accepted this cycle.
REQ-011 SHALL have port grant_o  output  num_req_g  registered one-hot owner; all zero when idle.
REQ-012 SHALL have port fifo_w_en_o  output  1  write enable to the downstream FIFO.
REQ-013 SHALL have port fifo_w_data_o  output  data_word_size_g  write data to the downstream FIFO.
REQ-014 SHALL have port fifo_full_i  input  1  downstream FIFO full flag.
REQ-015 SHALL have port busy_o  output  1  high while in BURST.

Function
REQ-016 SHALL implement two states: IDLE and BURST.
REQ-017 In IDLE with clk_en_i high and any req_i bit set, SHALL register the winner into grant_o and enter BURST on the next edge (1-cycle arbitration latency).
REQ-018 Winner SHALL be the first set req_i bit searching upward from (last_ptr+1) mod num_req_g, with wrap-around.
REQ-019 In BURST, a transfer SHALL occur combinationally when clk_en_i, req_i[g] high and fifo_full_i low, where g is the granted index: fifo_w_en_o=1, fifo_w_data_o=data_i slice g, ack_o[g]=1.
REQ-020 With no transfer, fifo_w_en_o and ack_o SHALL be 0; fifo_w_data_o SHALL be don't-care.
REQ-021 A burst counter SHALL clear on grant and increment per transfer.
REQ-022 BURST SHALL end (next state IDLE, grant_o cleared, last_ptr=g) when: the transfer has last_i[g]=1; OR the transfer makes the count equal to max_burst_g; OR req_i[g] is low while clk_en_i is high.
REQ-023 fifo_full_i high SHALL stall the burst without releasing grant and without counting.
REQ-024 Exactly one IDLE cycle SHALL separate consecutive grants; no transfer occurs in IDLE.
REQ-025 Requests from non-granted requesters SHALL never produce ack_o or fifo_w_en_o.
REQ-026 clk_en_i low SHALL hold state, grant_o, counter and last_ptr, and force fifo_w_en_o and ack_o to 0.

Reset
REQ-027 rst_i low SHALL immediately force state IDLE, grant_o=0, busy_o=0, counter=0, last_ptr=num_req_g-1 (requester 0 wins first).
REQ-028 fifo_w_en_o and ack_o SHALL be 0 while rst_i is low, including reset asserted mid-burst; partial bursts are abandoned.

Structure
REQ-029 State encodings and the counter-width constant (clog2(max_burst_g+1)) SHALL live in the shared fifo package.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_priority_pick (inputs req vector, last_ptr; outputs one-hot and index, valid).

Verification
REQ-031 Reset release, req_i=0001, last_i=0001 -> grant_o=0001 one cycle later, one ack_o[0], fifo_w_en_o for one cycle, then IDLE.
REQ-032 req_i=1111 held, last_i=1111 always -> grant order 0,1,2,3,0 with one idle cycle between each.
REQ-033 req_i=0010 held, last_i=0, max_burst_g=8 -> exactly 8 writes, then release, then requester 1 re-granted.
REQ-034 Mid-burst fifo_full_i high for 3 cycles -> fifo_w_en_o=0 for those 3 cycles, grant_o unchanged, total word count unchanged.
REQ-035 rst_i pulsed low mid-burst after 3 words -> grant_o=0 immediately; after release requester 0 wins first.
REQ-036 clk_en_i low for 2 cycles during BURST -> no writes, state/counter frozen, burst resumes unchanged.
